step_controller: RTL and testbench
==================================

# step_controller

Clock-enable sequencer for the processor core on the FPGA workbench. It replaces gating the core clock with a clean single-cycle enable (`core_ce`) on the board clock, and supports free-run, debounced single/burst stepping and one PC breakpoint. It sits between the board button/switches and the core's enable input, with `pc` fed back from the core.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles the synchronised button must stay high before a press is accepted (≥ 2).
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.
- `clk` input 1: board clock; sole clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_step` input 1: raw step button, asynchronous.
- `run_mode` input 1: raw run switch, asynchronous; 1 = free-run.
- `burst_len` input 8: enables issued per accepted press; 0 is treated as 1.
- `bp_enable` input 1: breakpoint enable, synchronous to `clk`.
- `bp_address` input 32: breakpoint PC.
- `pc` input 32: current core PC.
- `core_ce` output 1: core clock enable; core advances one cycle per high cycle.
- `halted` output 1: high in IDLE and BREAK.
- `state` output 2: current FSM state, for LEDs.
- `step_count` output 32: total `core_ce` cycles issued; wraps.

## Operation
- `btn_step` and `run_mode` each pass through a 2-flop synchroniser, giving `btn_s` and `run_s`.
- Debounce:
  - While `btn_s`=1, the counter increments and saturates at `DEBOUNCE_CYCLES`.
  - `press` is a 1-cycle pulse in the cycle the counter transitions from `DEBOUNCE_CYCLES-1` to `DEBOUNCE_CYCLES`.
  - `btn_s`=0 clears the counter, which re-arms the next press.
  - A held button yields exactly one press.
- `bp_hit` = `bp_enable && pc == bp_address`, 32-bit equality.
- FSM, with transitions taken on the clock edge:
  - IDLE: if `run_s`, go to RUN. Else if `press`, go to STEP and load `remaining` = (`burst_len`==0 ? 1 : `burst_len`). `run_s` has priority over `press`.
  - STEP: `core_ce`=1 and `remaining` decrements. When `remaining`==1, go to IDLE. `press`, `run_s` and `bp_hit` are all ignored in STEP.
  - RUN: if `run_s`=0, go to IDLE. Else if `bp_hit`, go to BREAK. `press` is ignored.
  - BREAK: if `run_s`=0, go to IDLE. Else if `press`, go to STEP and load `remaining` as above.
- `core_ce` = (state==STEP) || (state==RUN && !`bp_hit`). It is combinational, so the breakpoint instruction is not executed in RUN.
- Resume after a breakpoint: press step while `run_s` is still 1. The sequence is STEP → IDLE → RUN, and the burst moves the PC off the breakpoint.
- `step_count` increments by 1 in every cycle `core_ce`=1, wrapping mod 2^32.
- State encoding: IDLE=0, STEP=1, RUN=2, BREAK=3.

## Timing
- Reset values, all outputs: state=IDLE, `core_ce`=0, `halted`=1, `state`=0, `step_count`=0. Synchronisers, debounce counter and `remaining` are also 0. Reset asserted mid-burst or mid-run aborts immediately, with no further `core_ce`.
- Press latency: raw `btn_step` rising → `btn_s` 2 cycles later → `press` `DEBOUNCE_CYCLES` cycles after `btn_s` rises → state=STEP at the next edge. `core_ce` is high for exactly N consecutive cycles (N = effective burst), then low.
- `burst_len` is sampled only on the load edge; later changes do not affect the burst in progress.
- `run_mode` latency: 2 sync cycles, then 1 edge to enter or leave RUN.
- `bp_hit` stops `core_ce` in the same cycle. BREAK is entered at the next edge.

## Structure
- Package `pisa_debug_pkg`: `step_state_t` enum (ST_IDLE, ST_STEP, ST_RUN, ST_BREAK, 2 bits, values as above) and `BURST_W`=8.
- Sub-module `button_debouncer` (params `DEBOUNCE_CYCLES`, `CNT_W`; ports `clk`, `rst_n`, `raw`, `level`, `press`). It contains the synchroniser and counter. `run_mode` uses a bare 2-flop synchroniser in the top.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4.
1. Reset, then hold `btn_step` for 20 cycles with `burst_len`=0 → exactly 1 `core_ce` cycle, 7 cycles after the raw rise; `step_count`=1; one press only despite the hold.
2. `burst_len`=5, with a 2-cycle button glitch followed by a clean press → glitch produces nothing; press produces 5 consecutive `core_ce`; state returns to 0; `step_count`=5.
3. `run_mode`=1, `bp_enable`=1, `bp_address`=0x10, `pc` incrementing by 4 from 0 → `core_ce` high for pc 0..0xC, low at pc=0x10; state=3; `halted`=1.
4. From scenario 3, press with `burst_len`=1 and `pc` advanced to 0x14 → one `core_ce`, then IDLE, then RUN with `core_ce` continuous.
5. Raise `run_mode` during a 10-cycle burst → all 10 steps complete, then RUN; `step_count` is continuous.
6. Deassert `rst_n` mid-RUN with `step_count`=0x FFFF_FFFE → `core_ce`=0 immediately; `step_count`=0. A separate run from `step_count`=0xFFFF_FFFF wraps it to 0.

Source files
------------

// File: rtl/pisa_debug_pkg.sv
// Shared types for the core step/debug controller.
//   step_state_t : FSM state encoding, also driven out on the LED state port.
//   BURST_W      : width of the burst length / remaining-enable counter.
//   eff_burst    : maps a requested burst length to the number of enables issued.
package pisa_debug_pkg;

    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } step_state_t;

    // A zero-length burst still issues one enable.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] len);
        return (len == '0) ? BURST_W'(1) : len;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw asynchronous button and debounces it.
//   clk, rst_n : board clock, asynchronous active-low reset
//   raw        : raw button input (asynchronous)
//   level      : synchronised button level
//   press      : one-cycle pulse once the button has been high DEBOUNCE_CYCLES cycles
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntArm = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    assign level = sync_q[1];
    assign press = press_q;

    always_comb begin
        sync_d  = {sync_q[0], raw};
        cnt_d   = cnt_q;
        if (!level) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Registered so the pulse coincides with the first saturated cycle.
        press_d = level && (cnt_q == CntArm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/step_controller.sv
// Clock-enable sequencer for the core: free-run, debounced single/burst step and
// one PC breakpoint, all on the board clock.
//   clk, rst_n  : board clock, asynchronous active-low reset
//   btn_step    : raw step button (asynchronous)
//   run_mode    : raw run switch (asynchronous), 1 = free-run
//   burst_len   : enables per accepted press (0 behaves as 1)
//   bp_enable   : breakpoint enable
//   bp_address  : breakpoint PC
//   pc          : current core PC
//   core_ce     : core clock enable
//   halted      : high in IDLE and BREAK
//   state       : current FSM state for LEDs
//   step_count  : total enables issued, wrapping
module step_controller
    import pisa_debug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_step,
    input  logic               run_mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               bp_enable,
    input  logic [31:0]        bp_address,
    input  logic [31:0]        pc,
    output logic               core_ce,
    output logic               halted,
    output logic [1:0]         state,
    output logic [31:0]        step_count
);

    step_state_t        state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic [31:0]        step_count_q, step_count_d;
    logic [1:0]         run_sync_q, run_sync_d;
    logic               run_s;
    logic               btn_level;
    logic               btn_press;
    logic               press;
    logic               bp_hit;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (btn_level),
        .press (btn_press)
    );

    // Drop a press whose button already let go in the pulse cycle.
    assign press  = btn_press && btn_level;
    assign run_s  = run_sync_q[1];
    assign bp_hit = bp_enable && (pc == bp_address);

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        core_ce      = 1'b0;
        run_sync_d   = {run_sync_q[0], run_mode};
        unique case (state_q)
            ST_IDLE: begin
                if (run_s) begin
                    state_d = ST_RUN;
                end else if (press) begin
                    state_d     = ST_STEP;
                    remaining_d = eff_burst(burst_len);
                end
            end
            ST_STEP: begin
                core_ce     = 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q <= BURST_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Combinational stop: the breakpoint instruction never executes.
                core_ce = !bp_hit;
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else if (press) begin
                    state_d     = ST_STEP;
                    remaining_d = eff_burst(burst_len);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        step_count_d = step_count_q + 32'(core_ce);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            step_count_q <= '0;
            run_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            step_count_q <= step_count_d;
            run_sync_q   <= run_sync_d;
        end
    end

    assign halted     = (state_q == ST_IDLE) || (state_q == ST_BREAK);
    assign state      = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_step_controller.sv
module tb_step_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_step;
    logic        run_mode;
    logic [7:0]  burst_len;
    logic        bp_enable;
    logic [31:0] bp_address;
    logic [31:0] pc;
    logic        core_ce;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] step_count;

    step_controller #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .run_mode   (run_mode),
        .burst_len  (burst_len),
        .bp_enable  (bp_enable),
        .bp_address (bp_address),
        .pc         (pc),
        .core_ce    (core_ce),
        .halted     (halted),
        .state      (state),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   pc_track = 1'b0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: observed %h, expected nothing queued", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: observed %h, expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // One clock; acts as the core: pc advances by 4 for every enabled cycle.
    // Returns at the falling edge, where outputs are sampled and inputs driven.
    task automatic tick();
        logic ce_n;
        #1 ce_n = core_ce;
        @(posedge clk);
        #1 if (pc_track && ce_n) pc = pc + 32'd4;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        int          ce_cnt;
        int          run_len;
        int          max_run;
        logic        ce_at_bp;
        bit          seen;
        logic [1:0]  st4 [5];
        logic        ce4 [5];

        rst_n      = 1'b0;
        btn_step   = 1'b0;
        run_mode   = 1'b0;
        burst_len  = 8'd0;
        bp_enable  = 1'b0;
        bp_address = 32'h0;
        pc         = 32'h0;
        repeat (2) @(negedge clk);

        // Reset values
        expect_val("rst_state", 32'd0);      check(32'(state));
        expect_val("rst_ce", 32'd0);         check(32'(core_ce));
        expect_val("rst_halted", 32'd1);     check(32'(halted));
        expect_val("rst_count", 32'd0);      check(step_count);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: held button, burst 0 -> one enable, 7 cycles after raw rise
        burst_len = 8'd0;
        btn_step  = 1'b1;
        expect_val("t1_latency", 32'd7);
        expect_val("t1_ce_total", 32'd1);
        expect_val("t1_count", 32'd1);
        expect_val("t1_state", 32'd0);
        first  = 0;
        ce_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (core_ce === 1'b1) begin
                ce_cnt++;
                if (first == 0) first = i;
            end
        end
        btn_step = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (core_ce === 1'b1) ce_cnt++;
        end
        check(32'(first));
        check(32'(ce_cnt));
        check(step_count);
        check(32'(state));

        // 2: 2-cycle glitch ignored, then clean press with burst 5
        burst_len = 8'd5;
        expect_val("t2_glitch_ce", 32'd0);
        ce_cnt   = 0;
        btn_step = 1'b1;
        tick();
        if (core_ce === 1'b1) ce_cnt++;
        tick();
        if (core_ce === 1'b1) ce_cnt++;
        btn_step = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (core_ce === 1'b1) ce_cnt++;
        end
        check(32'(ce_cnt));

        expect_val("t2_ce_total", 32'd5);
        expect_val("t2_ce_consecutive", 32'd5);
        expect_val("t2_state", 32'd0);
        expect_val("t2_count", 32'd6);       // 1 from scenario 1 + 5
        ce_cnt   = 0;
        run_len  = 0;
        max_run  = 0;
        btn_step = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 19) btn_step = 1'b0;
            if (core_ce === 1'b1) begin
                ce_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
        check(32'(ce_cnt));
        check(32'(max_run));
        check(32'(state));
        check(step_count);

        // 3: free-run into a breakpoint at 0x10
        pc         = 32'h0;
        bp_address = 32'h10;
        bp_enable  = 1'b1;
        pc_track   = 1'b1;
        run_mode   = 1'b1;
        expect_val("t3_ce_before_bp", 32'd4);
        expect_val("t3_ce_at_bp", 32'd0);
        expect_val("t3_pc", 32'h10);
        expect_val("t3_state", 32'd3);
        expect_val("t3_halted", 32'd1);
        expect_val("t3_count", 32'd10);
        ce_cnt   = 0;
        seen     = 1'b0;
        ce_at_bp = 1'bx;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_ce === 1'b1) ce_cnt++;
            if (pc == 32'h10 && !seen) begin
                seen     = 1'b1;
                ce_at_bp = core_ce;
            end
            if (state == 2'd3) break;
        end
        check(32'(ce_cnt));
        check(32'(ce_at_bp));
        check(pc);
        check(32'(state));
        check(32'(halted));
        check(step_count);

        // 4: resume from the breakpoint: STEP -> IDLE -> RUN
        pc        = 32'h14;
        burst_len = 8'd1;
        btn_step  = 1'b1;
        st4 = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd2};
        ce4 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            expect_val($sformatf("t4_state%0d", k), 32'(st4[k]));
            expect_val($sformatf("t4_ce%0d", k), 32'(ce4[k]));
        end
        expect_val("t4_count", 32'd13);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state != 2'd3) break;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check(32'(state));
            check(32'(core_ce));
        end
        check(step_count);

        run_mode  = 1'b0;
        bp_enable = 1'b0;
        btn_step  = 1'b0;
        expect_val("t4_exit_state", 32'd0);
        expect_val("t4_exit_count", 32'd16);
        repeat (8) tick();
        check(32'(state));
        check(step_count);

        // 5: run switch raised mid-burst; burst_len change after load ignored
        burst_len = 8'd10;
        btn_step  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_val($sformatf("t5_state%0d", k), 32'd1);
            expect_val($sformatf("t5_ce%0d", k), 32'd1);
        end
        expect_val("t5_state10", 32'd0);
        expect_val("t5_ce10", 32'd0);
        for (int k = 11; k < 13; k++) begin
            expect_val($sformatf("t5_state%0d", k), 32'd2);
            expect_val($sformatf("t5_ce%0d", k), 32'd1);
        end
        expect_val("t5_count", 32'd27);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state == 2'd1) break;
        end
        btn_step  = 1'b0;
        burst_len = 8'd3;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            if (k == 1) run_mode = 1'b1;
            check(32'(state));
            check(32'(core_ce));
        end
        check(step_count);

        // 6: reset mid-run near the top of the counter
        force dut.step_count_q = 32'hFFFF_FFFE;
        tick();
        release dut.step_count_q;
        expect_val("t6_preload", 32'hFFFF_FFFE);
        check(step_count);
        tick();
        expect_val("t6_run_inc", 32'hFFFF_FFFF);
        check(step_count);
        #2 rst_n = 1'b0;
        expect_val("t6_rst_ce", 32'd0);
        expect_val("t6_rst_count", 32'd0);
        expect_val("t6_rst_state", 32'd0);
        expect_val("t6_rst_hold_ce", 32'd0);
        #1;
        check(32'(core_ce));
        check(step_count);
        check(32'(state));
        ce_cnt = 0;
        repeat (2) begin
            tick();
            if (core_ce !== 1'b0) ce_cnt++;
        end
        check(32'(ce_cnt));
        rst_n = 1'b1;

        // Separate run from 0xFFFF_FFFF wraps to 0
        force dut.step_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.step_count_q;
        expect_val("t6_wrap_preload", 32'hFFFF_FFFF);
        expect_val("t6_wrap_first_ce", 32'd1);
        expect_val("t6_wrap_hold", 32'hFFFF_FFFF);
        expect_val("t6_wrap", 32'd0);
        check(step_count);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (core_ce === 1'b1) break;
        end
        check(32'(core_ce));
        check(step_count);
        tick();
        check(step_count);

        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: observed %0d queued, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
